spi_slave: RTL and testbench
============================

# spi_slave

SPI slave front end that feeds the single-port command RAM. It deserialises 10-bit MOSI frames into `rx_data`/`rx_valid` commands for the RAM. On a read-data frame it captures the RAM's 8-bit response and serialises it MSB-first on MISO. The SPI bit clock is the system clock `clk`; the master changes MOSI and SS_n only between rising edges.

## Interface
- `ADDR_SIZE`, default 8: RAM address/data width; frame width is `ADDR_SIZE+2`.
- `clk` input, 1 bit: system clock, also the SPI bit clock; all logic uses the rising edge.
- `rst_n` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `SS_n` input, 1 bit: slave select, active-low; frame boundary.
- `MOSI` input, 1 bit: serial data in, MSB first.
- `MISO` output, 1 bit: serial data out, MSB first; 0 when not shifting.
- `rx_data` output, `ADDR_SIZE+2` bits: received frame `{cmd[1:0], payload}`.
- `rx_valid` output, 1 bit: one-cycle strobe; `rx_data` is valid.
- `tx_data` input, `ADDR_SIZE` bits: read data from RAM.
- `tx_valid` input, 1 bit: RAM read data valid; may stay high indefinitely (sticky).

## Operation
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. Internal flag `rd_addr_received`, reset 0.
- IDLE: while SS_n=1, stay. On SS_n=0, go to CHK_CMD.
- CHK_CMD: sample MOSI as frame bit 9 and route:
  - MOSI=0 -> WRITE.
  - MOSI=1, flag=0 -> READ_ADD.
  - MOSI=1, flag=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift in frame bits 8..0, one per edge.
- Frame complete: on the edge sampling bit 0, register `rx_data` with the full frame and set `rx_valid`=1 for exactly one cycle.
- Routing uses only bit 9 and the flag. The frame, including bit 8, is forwarded unmodified; the RAM decodes the command.
- End of READ_ADD frame: set the flag.
- READ_DATA after `rx_valid`:
  - Wait for `tx_valid`=1, sampled on an edge strictly after the edge where `rx_valid` was high. This rejects a stale sticky `tx_valid`.
  - On that edge, load `tx_data` and drive MISO=bit 7.
  - On each following edge, output the next bit.
  - On the edge after bit 0, MISO returns to 0 and the flag clears.
- After a completed frame, extra MOSI bits are ignored until SS_n=1.
- Any state, SS_n=1 sampled: next state is IDLE. The bit counter clears, MISO=0, no `rx_valid` for a partial frame, and the flag is unchanged.
- Reset: state IDLE, flag 0, counters 0, `rx_data`=0, `rx_valid`=0, MISO=0.

## Timing
- Edge numbering: E0 samples SS_n=0 in IDLE; E1 samples bit 9; E2..E10 sample bits 8..0.
- `rx_valid` is high in the cycle between E10 and E11.
- The RAM registers read data at E11. The slave captures at E12.
- MISO carries bit 7 after E12 and bit 0 after E19. MISO=0 and the flag clears after E20.
- Master must hold SS_n low through E20 on read-data frames, and through E10 otherwise.
- Minimum SS_n-high gap between frames: one edge.
- Asynchronous reset mid-frame: immediate return to reset values, no partial `rx_valid`.
- SS_n rising on the same edge as the bit 0 sample: the frame completes (`rx_valid` pulses), then the block enters IDLE.

## Structure
- Shared package `spi_pkg` holds:
  - the state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - command codes: `CMD_WR_ADDR`=00, `CMD_WR_DATA`=01, `CMD_RD_ADDR`=10, `CMD_RD_DATA`=11.
- No sub-module is needed. The block is one FSM plus a shift register, a bit counter and a one-bit flag. A separate top-level wrapper instantiates `spi_slave` alongside the RAM.

## Test plan
- Write address: SS_n low, MOSI frame 00_0000_0101 -> `rx_valid` pulses one cycle with `rx_data`=0x005; MISO stays 0.
- Write data: frame 01_1010_1010 -> `rx_data`=0x1AA; flag stays 0.
- Read address: frame 10_0000_0101 -> `rx_data`=0x205, flag=1. Read data: next frame 11_xxxx_xxxx -> routed to READ_DATA, `rx_data`=0x3xx. RAM returns 0xAA -> MISO=1,0,1,0,1,0,1,0 after E12..E19, then flag=0.
- Stale `tx_valid`: hold `tx_valid`=1 with `tx_data`=0x55 before the read-data frame, and switch `tx_data` to 0xC3 at E11 -> MISO shifts 0xC3, not 0x55.
- Abort: raise SS_n after 5 bits of frame 10_... -> no `rx_valid`, flag unchanged, IDLE next edge. The next full frame decodes normally.
- Reset: assert `rst_n`=0 mid-MISO-shift -> MISO, `rx_valid` and `rx_data` go to 0 immediately. After release, a frame starting with 1 routes to READ_ADD.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command front end: FSM states and the
// two-bit command codes carried in the top bits of every frame.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic logic cmd_is_read(input logic [1:0] cmd);
    return (cmd == CMD_RD_ADDR) || (cmd == CMD_RD_DATA);
  endfunction

  function automatic logic cmd_is_write(input logic [1:0] cmd);
    return (cmd == CMD_WR_ADDR) || (cmd == CMD_WR_DATA);
  endfunction

  // Only the command MSB is known when routing; the read-address flag picks
  // between the two read states.
  function automatic state_e route_cmd(input logic cmd_msb, input logic rd_addr_received);
    if (!cmd_is_read({cmd_msb, 1'b0}))
      return WRITE;
    else if (rd_addr_received)
      return READ_DATA;
    else
      return READ_ADD;
  endfunction

endpackage

// File: rtl/spi_slave.sv
// SPI slave: deserialises (ADDR_SIZE+2)-bit MOSI frames into rx_data/rx_valid
// and, after a read-data frame, serialises the RAM's response MSB-first on MISO.
module spi_slave
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FRAME_W  = ADDR_SIZE + 2;
  localparam int CNT_W    = $clog2(FRAME_W + 1);
  localparam int TX_CNT_W = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;

  state_e                state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg;
  logic [FRAME_W-2:0]    shift_reg;
  logic [FRAME_W-1:0]    rx_data_reg;
  logic                  rx_valid_reg;
  logic                  rd_addr_received_reg;
  logic                  tx_armed_reg;
  logic                  tx_busy_reg;
  logic [ADDR_SIZE-1:0]  tx_shift_reg;
  logic [TX_CNT_W-1:0]   tx_cnt_reg;
  logic                  miso_reg;

  logic                  frame_active;
  logic                  frame_done;
  logic                  tx_load;

  assign frame_active = (state_reg == WRITE) || (state_reg == READ_ADD) ||
                        (state_reg == READ_DATA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    frame_done = 1'b0;
    tx_load    = 1'b0;

    case (state_reg)
      IDLE:    if (!SS_n) state_next = CHK_CMD;
      CHK_CMD: state_next = route_cmd(MOSI, rd_addr_received_reg);
      default: state_next = state_reg;
    endcase

    // A frame whose last bit is sampled together with SS_n rising still completes.
    frame_done = frame_active && (bit_cnt_reg == CNT_W'(FRAME_W - 1));

    // tx_armed_reg is set one edge after the rx_valid edge, so a sticky
    // tx_valid left over from an earlier read cannot be captured.
    tx_load = (state_reg == READ_DATA) && tx_armed_reg && tx_valid && !SS_n;

    if (SS_n)
      state_next = IDLE;
  end

  // Receive path: bit counter, shift register and the completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_valid_reg <= frame_done;
      if (frame_done)
        rx_data_reg <= {shift_reg, MOSI};

      if (SS_n) begin
        bit_cnt_reg <= '0;
      end else if (state_reg == CHK_CMD) begin
        bit_cnt_reg <= CNT_W'(1);
        shift_reg   <= {shift_reg[FRAME_W-3:0], MOSI};
      end else if (frame_active && (bit_cnt_reg < CNT_W'(FRAME_W))) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        shift_reg   <= {shift_reg[FRAME_W-3:0], MOSI};
      end
    end
  end

  // Transmit path and the read-address flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_received_reg <= 1'b0;
      tx_armed_reg         <= 1'b0;
      tx_busy_reg          <= 1'b0;
      tx_shift_reg         <= '0;
      tx_cnt_reg           <= '0;
      miso_reg             <= 1'b0;
    end else begin
      if (frame_done && (state_reg == READ_ADD))
        rd_addr_received_reg <= 1'b1;
      else if (tx_busy_reg && (tx_cnt_reg == '0) && !SS_n)
        rd_addr_received_reg <= 1'b0;

      if (SS_n) begin
        tx_armed_reg <= 1'b0;
        tx_busy_reg  <= 1'b0;
        miso_reg     <= 1'b0;
      end else if (tx_load) begin
        tx_armed_reg <= 1'b0;
        tx_busy_reg  <= 1'b1;
        miso_reg     <= tx_data[ADDR_SIZE-1];
        tx_shift_reg <= {tx_data[ADDR_SIZE-2:0], 1'b0};
        tx_cnt_reg   <= TX_CNT_W'(ADDR_SIZE - 1);
      end else if (tx_busy_reg) begin
        if (tx_cnt_reg == '0) begin
          tx_busy_reg <= 1'b0;
          miso_reg    <= 1'b0;
        end else begin
          miso_reg     <= tx_shift_reg[ADDR_SIZE-1];
          tx_shift_reg <= {tx_shift_reg[ADDR_SIZE-2:0], 1'b0};
          tx_cnt_reg   <= tx_cnt_reg - 1'b1;
        end
      end else if (rx_valid_reg && (state_reg == READ_DATA)) begin
        tx_armed_reg <= 1'b1;
      end
    end
  end

  assign MISO     = miso_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Directed self-checking bench for spi_slave: write/read frames, stale
// tx_valid rejection, abort, back-to-back frames and asynchronous reset.
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int total = 0;
  int bad = 0;

  spi_slave #(.ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Drops SS_n, then drives nbits of f MSB-first; returns on the negedge
  // where the last bit was driven (it is sampled on the next rising edge).
  task automatic send_bits(input logic [9:0] f, input int nbits, input logic raise_last);
    @(negedge clk); SS_n = 1'b0; MOSI = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      MOSI = f[9-i];
      if (raise_last && i == nbits - 1) SS_n = 1'b1;
    end
  endtask

  task automatic do_write(input logic [9:0] f);
    send_bits(f, 10, 1'b0);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wr_early_valid got=%b want=0", rx_valid); end
    @(negedge clk);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL wr_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== f) begin bad++; $display("FAIL wr_data got=%03h want=%03h", rx_data, f); end
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL wr_miso got=%b want=0", MISO); end
    total++; if (dut.rd_addr_received_reg !== 1'b0) begin bad++; $display("FAIL wr_flag got=%b want=0", dut.rd_addr_received_reg); end
    SS_n = 1'b1;
    @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wr_valid_width got=%b want=0", rx_valid); end
    total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL wr_idle got=%0d want=%0d", dut.state_reg, IDLE); end
    $display("[tb] write frame %03h", f);
  endtask

  task automatic do_read_addr(input logic [9:0] f);
    send_bits(f, 10, 1'b0);
    total++; if (dut.state_reg !== READ_ADD) begin bad++; $display("FAIL ra_route got=%0d want=%0d", dut.state_reg, READ_ADD); end
    @(negedge clk);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL ra_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== f) begin bad++; $display("FAIL ra_data got=%03h want=%03h", rx_data, f); end
    total++; if (dut.rd_addr_received_reg !== 1'b1) begin bad++; $display("FAIL ra_flag got=%b want=1", dut.rd_addr_received_reg); end
    SS_n = 1'b1;
    @(negedge clk);
    $display("[tb] read-address frame %03h", f);
  endtask

  task automatic do_read_data(input logic [9:0] f, input logic [7:0] d,
                              input logic stale, input logic [7:0] stale_d);
    tx_valid = stale;
    tx_data  = stale_d;
    send_bits(f, 10, 1'b0);
    total++; if (dut.state_reg !== READ_DATA) begin bad++; $display("FAIL rd_route got=%0d want=%0d", dut.state_reg, READ_DATA); end
    @(negedge clk);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL rd_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== f) begin bad++; $display("FAIL rd_data got=%03h want=%03h", rx_data, f); end
    @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_miso_pre got=%b want=0", MISO); end
    tx_valid = 1'b1;
    tx_data  = d;
    for (int k = 7; k >= 0; k--) begin
      @(negedge clk);
      total++; if (MISO !== d[k]) begin bad++; $display("FAIL rd_miso_bit%0d got=%b want=%b", k, MISO, d[k]); end
    end
    @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_miso_post got=%b want=0", MISO); end
    total++; if (dut.rd_addr_received_reg !== 1'b0) begin bad++; $display("FAIL rd_flag_clr got=%b want=0", dut.rd_addr_received_reg); end
    SS_n = 1'b1;
    tx_valid = 1'b0;
    @(negedge clk);
    $display("[tb] read-data frame %03h -> miso %02h", f, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b want=0", MISO); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", rx_valid); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL rst_data got=%03h want=000", rx_data); end
    total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL rst_state got=%0d want=%0d", dut.state_reg, IDLE); end
    total++; if (dut.rd_addr_received_reg !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b want=0", dut.rd_addr_received_reg); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("[tb] reset");
  endtask

  task automatic test_write();
    do_write(10'h005);
    do_write(10'h1AA);
  endtask

  task automatic test_read();
    do_read_addr(10'h205);
    do_read_data(10'h3A5, 8'hAA, 1'b0, 8'h00);
  endtask

  task automatic test_stale_tx_valid();
    do_read_addr(10'h2F0);
    do_read_data(10'h3F0, 8'hC3, 1'b1, 8'h55);
  endtask

  task automatic test_abort();
    send_bits(10'h2C0, 5, 1'b0);
    @(negedge clk);
    total++; if (dut.state_reg !== READ_ADD) begin bad++; $display("FAIL ab_mid got=%0d want=%0d", dut.state_reg, READ_ADD); end
    SS_n = 1'b1;
    @(negedge clk);
    total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL ab_idle got=%0d want=%0d", dut.state_reg, IDLE); end
    for (int i = 0; i < 3; i++) begin
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ab_valid got=%b want=0", rx_valid); end
      @(negedge clk);
    end
    total++; if (dut.rd_addr_received_reg !== 1'b0) begin bad++; $display("FAIL ab_flag0 got=%b want=0", dut.rd_addr_received_reg); end
    $display("[tb] aborted frame with flag clear");

    do_read_addr(10'h211);
    send_bits(10'h3FF, 4, 1'b0);
    @(negedge clk);
    total++; if (dut.state_reg !== READ_DATA) begin bad++; $display("FAIL ab_rd_mid got=%0d want=%0d", dut.state_reg, READ_DATA); end
    SS_n = 1'b1;
    @(negedge clk);
    total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL ab_rd_idle got=%0d want=%0d", dut.state_reg, IDLE); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ab_rd_valid got=%b want=0", rx_valid); end
    total++; if (dut.rd_addr_received_reg !== 1'b1) begin bad++; $display("FAIL ab_flag1 got=%b want=1", dut.rd_addr_received_reg); end
    $display("[tb] aborted frame with flag set");
    do_read_data(10'h3C0, 8'h96, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    send_bits(10'h0AB, 10, 1'b0);
    @(negedge clk);
    total++; if (rx_data !== 10'h0AB) begin bad++; $display("FAIL bb_first got=%03h want=0AB", rx_data); end
    MOSI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL bb_extra_valid got=%b want=0", rx_valid); end
    end
    total++; if (rx_data !== 10'h0AB) begin bad++; $display("FAIL bb_extra_data got=%03h want=0AB", rx_data); end
    SS_n = 1'b1;
    $display("[tb] write frame 0ab with trailing bits");
    send_bits(10'h17E, 10, 1'b1);
    @(negedge clk);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL bb_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== 10'h17E) begin bad++; $display("FAIL bb_data got=%03h want=17E", rx_data); end
    total++; if (dut.state_reg !== IDLE) begin bad++; $display("FAIL bb_idle got=%0d want=%0d", dut.state_reg, IDLE); end
    @(negedge clk);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL bb_valid_width got=%b want=0", rx_valid); end
    $display("[tb] back-to-back frame 17e ending with SS_n rise");
  endtask

  task automatic test_reset_mid_shift();
    do_read_addr(10'h2AA);
    tx_valid = 1'b0;
    send_bits(10'h3AA, 10, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hF0;
    @(negedge clk);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rm_bit7 got=%b want=1", MISO); end
    @(negedge clk);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rm_bit6 got=%b want=1", MISO); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rm_miso got=%b want=0", MISO); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", rx_valid); end
    total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL rm_data got=%03h want=000", rx_data); end
    total++; if (dut.rd_addr_received_reg !== 1'b0) begin bad++; $display("FAIL rm_flag got=%b want=0", dut.rd_addr_received_reg); end
    @(negedge clk);
    rst_n = 1'b1;
    SS_n = 1'b1;
    tx_valid = 1'b0;
    $display("[tb] async reset during MISO shift");
    do_read_addr(10'h203);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_stale_tx_valid();
    test_abort();
    test_back_to_back();
    test_reset_mid_shift();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
